// File: rtl/trng_bit_collector.sv
// Raw entropy bit collector: synchroniser, sample strobe, optional von Neumann
// corrector (TRNG_VON_NEUMANN_EN), word packer, valid/ready holding register, repetition-count health test.
module trng_bit_collector #(
    parameter int SAMPLE_DIV = 16,
    parameter int REP_LIMIT  = 32,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              fault
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int PW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);
    localparam logic [PW-1:0] PK_FULL  = PW'(DATA_W);

    logic              s1, s2;
    logic [CW-1:0]     cnt;
    logic              strobe;
    logic [RW-1:0]     rep_cnt, rep_nxt;
    logic              prev;
    logic              fault_trip;
    logic              emit, emit_bit;
    logic [DATA_W-1:0] pk_word, hold;
    logic [PW-1:0]     pk_cnt;
    logic              pk_full, load, xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    always_comb begin
        strobe = en && (cnt == CNT_LAST);
        // rep_cnt == 0 marks "no previous sample since reset or enable"
        rep_nxt = RW'(1);
        if (rep_cnt != '0 && s2 == prev) begin
            rep_nxt = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + RW'(1);
        end
        fault_trip = strobe && !fault && (rep_nxt == REP_MAX);
        pk_full    = (pk_cnt == PK_FULL);
        xfer       = valid && ready;
        load       = pk_full && (!valid || xfer) && !fault && !fault_trip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            prev    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            if (!en) begin
                rep_cnt <= '0;
            end else if (strobe) begin
                rep_cnt <= rep_nxt;
                prev    <= s2;
            end
            if (fault_trip) begin
                fault <= 1'b1;
            end
        end
    end

`ifdef TRNG_VON_NEUMANN_EN
    logic pair_have, pair_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_have <= 1'b0;
            pair_a    <= 1'b0;
        end else if (!en || fault) begin
            pair_have <= 1'b0;
        end else if (strobe) begin
            pair_have <= !pair_have;
            if (!pair_have) begin
                pair_a <= s2;
            end
        end
    end

    always_comb begin
        emit     = strobe && pair_have && (pair_a != s2);
        emit_bit = pair_a;
    end
`else
    always_comb begin
        emit     = strobe;
        emit_bit = s2;
    end
`endif

    // A completed word survives en=0 so it can still reach the holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_word <= '0;
            pk_cnt  <= '0;
        end else if (fault || fault_trip || load || (!en && !pk_full)) begin
            pk_word <= '0;
            pk_cnt  <= '0;
        end else if (emit && !pk_full) begin
            pk_word <= {pk_word[DATA_W-2:0], emit_bit};
            pk_cnt  <= pk_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold  <= '0;
            valid <= 1'b0;
        end else if (fault_trip) begin
            hold  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            hold  <= pk_word;
            valid <= 1'b1;
        end else if (xfer) begin
            valid <= 1'b0;
        end
    end

    assign data_out = hold;

endmodule

// File: tb/tb_trng_bit_collector.sv
// Scoreboard bench for trng_bit_collector (SAMPLE_DIV=4, REP_LIMIT=8, DATA_W=8);
// stimulus adapts to whether TRNG_VON_NEUMANN_EN is defined.
module tb_trng_bit_collector;

    localparam int SD = 4;
    localparam int RL = 8;
    localparam int DW = 8;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b0;
    logic          raw_in = 1'b0;
    logic          ready  = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          fault;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];

    trng_bit_collector #(.SAMPLE_DIV(SD), .REP_LIMIT(RL), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .raw_in(raw_in),
        .data_out(data_out), .valid(valid), .ready(ready), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every presented word must match the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else begin
                    chk("word", {24'h0, data_out}, {24'h0, exp_q[0]});
                    if (ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // One sample held for one full strobe period, aligned to the en rising edge.
    task automatic samp(input logic b);
        raw_in = b;
        repeat (SD) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
`ifdef TRNG_VON_NEUMANN_EN
        samp(b);
        samp(~b);
`else
        samp(b);
`endif
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic junk);
        for (int i = DW - 1; i >= 0; i--) begin
`ifdef TRNG_VON_NEUMANN_EN
            if (junk && (i % 2 == 1)) begin
                samp((i % 4) == 1);
                samp((i % 4) == 1);
            end
`endif
            send_bit(w[i]);
        end
    endtask

    task automatic stop_en();
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset with raw_in toggling
        repeat (6) begin
            @(negedge clk);
            raw_in = ~raw_in;
        end
        chk("rst_data", {24'h0, data_out}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Packing, with discard pairs interleaved when the corrector is present
        ready = 1'b1;
        exp_q.push_back(8'hB2);
        en = 1'b1;
        send_word(8'hB2, 1'b1);
        chk("valid_not_early", {31'h0, valid}, 32'h0);
        stop_en();
        chk("valid_rise", {31'h0, valid}, 32'h1);
        @(negedge clk);
        chk("valid_drop", {31'h0, valid}, 32'h0);
        chk("pack_drained", exp_q.size(), 32'h0);

        // Backpressure: first held, second waits in packer, third dropped
        ready = 1'b0;
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'h5A);
        en = 1'b1;
        send_word(8'hB2, 1'b0);
        send_word(8'h5A, 1'b0);
        send_word(8'hC3, 1'b0);
        stop_en();
        chk("bp_first_valid", {31'h0, valid}, 32'h1);
        chk("bp_first_data", {24'h0, data_out}, 32'hB2);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("bp_valid_held", {31'h0, valid}, 32'h1);
        chk("bp_second_data", {24'h0, data_out}, 32'h5A);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_third_dropped", {31'h0, valid}, 32'h0);
        chk("bp_drained", exp_q.size(), 32'h0);

        // Health test with a word waiting in the holding register
        ready = 1'b0;
        exp_q.push_back(8'h69);
        en = 1'b1;
        send_word(8'h69, 1'b0);
        stop_en();
        chk("ht_word_held", {31'h0, valid}, 32'h1);
        en = 1'b1;
        repeat (RL - 1) samp(1'b1);
        chk("ht_no_fault_early", {31'h0, fault}, 32'h0);
        samp(1'b1);
        chk("ht_fault", {31'h0, fault}, 32'h1);
        chk("ht_valid_cleared", {31'h0, valid}, 32'h0);
        chk("ht_data_cleared", {24'h0, data_out}, 32'h0);
        exp_q.delete();
        samp(1'b0);
        samp(1'b1);
        stop_en();
        en = 1'b1;
        samp(1'b0);
        samp(1'b1);
        chk("ht_fault_sticky", {31'h0, fault}, 32'h1);
        chk("ht_no_output", {31'h0, valid}, 32'h0);
        stop_en();
        rst_n = 1'b0;
        @(negedge clk);
        chk("ht_fault_reset", {31'h0, fault}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Enable dropped mid-word: stale bits must not appear
        ready = 1'b1;
        en = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        stop_en();
        exp_q.push_back(8'h5A);
        en = 1'b1;
        send_word(8'h5A, 1'b0);
        stop_en();
        repeat (2) @(negedge clk);
        chk("en_word_seen", exp_q.size(), 32'h0);
        chk("en_valid_idle", {31'h0, valid}, 32'h0);

        // Asynchronous reset between clock edges
        ready = 1'b0;
        exp_q.push_back(8'h3C);
        en = 1'b1;
        send_word(8'h3C, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("ar_valid_before", {31'h0, valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("ar_valid", {31'h0, valid}, 32'h0);
        chk("ar_data", {24'h0, data_out}, 32'h0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
